// File: rtl/memory_parity_check_if.sv
// Bus bundle for the duplex memory parity checker: both buffer registers, the
// sample/clear controls and every result the checker reports back.
interface memory_parity_check_if #(
  parameter int CNT_W = 4
);
  logic [14:1]      bra;
  logic [14:1]      brb;
  logic             syls;
  logic             errclr;
  logic [13:1]      data;
  logic             valid;
  logic             perra;
  logic             perrb;
  logic             disag;
  logic             derr;
  logic [1:0]       chst;
  logic [CNT_W-1:0] errcnt;

  modport master (
    output bra, brb, syls, errclr,
    input  data, valid, perra, perrb, disag, derr, chst, errcnt
  );

  modport slave (
    input  bra, brb, syls, errclr,
    output data, valid, perra, perrb, disag, derr, chst, errcnt
  );
endinterface

// File: rtl/memory_parity_check.sv
// Duplex memory parity checker: two-stage pipeline that checks both channels,
// picks a usable word and tracks channel health. PARITY_ERRCNT_EN builds the error counter.
module memory_parity_check #(
  parameter int PAR_ODD = 1,
  parameter int CNT_W   = 4
) (
  input logic clk,
  input logic reset,
  memory_parity_check_if.slave bus
);

  localparam logic [1:0] BOTH_OK = 2'd0;
  localparam logic [1:0] A_ONLY  = 2'd1;
  localparam logic [1:0] B_ONLY  = 2'd2;
  localparam logic [1:0] FAILED  = 2'd3;

  localparam logic ODD = (PAR_ODD != 0);

  logic [14:1] s1_a;
  logic [14:1] s1_b;
  logic        s1_vld;

  logic [13:1] data_q;
  logic        valid_q;
  logic        perra_q;
  logic        perrb_q;
  logic        disag_q;
  logic        derr_q;
  logic [1:0]  chst_q;

  logic        a_good;
  logic        b_good;
  logic        a_use;
  logic        b_use;
  logic [1:0]  base_st;
  logic [1:0]  next_st;
  logic [13:1] sel_data;
  logic        sel_derr;

  // Stage 1: capture both buffer registers whenever the strobe is present.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else begin
      s1_vld <= bus.syls;
      if (bus.syls) begin
        s1_a <= bus.bra;
        s1_b <= bus.brb;
      end
    end
  end

  assign a_good = ((^s1_a) == ODD);
  assign b_good = ((^s1_b) == ODD);

  // A coincident clear acts first, so selection and transitions start from BOTH_OK.
  always_comb begin
    base_st = bus.errclr ? BOTH_OK : chst_q;
    a_use   = a_good && ((base_st == BOTH_OK) || (base_st == A_ONLY));
    b_use   = b_good && ((base_st == BOTH_OK) || (base_st == B_ONLY));
    next_st = base_st;
    case (base_st)
      BOTH_OK: begin
        if (!a_good && !b_good) next_st = FAILED;
        else if (!a_good)       next_st = B_ONLY;
        else if (!b_good)       next_st = A_ONLY;
      end
      A_ONLY:  if (!a_good) next_st = FAILED;
      B_ONLY:  if (!b_good) next_st = FAILED;
      default: next_st = FAILED;
    endcase
    sel_data = (b_use && !a_use) ? s1_b[13:1] : s1_a[13:1];
    sel_derr = !a_use && !b_use;
  end

  // Stage 2: later assignments to the sticky flags override the clear above them.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perra_q <= 1'b0;
      perrb_q <= 1'b0;
      disag_q <= 1'b0;
      derr_q  <= 1'b0;
      chst_q  <= BOTH_OK;
    end else begin
      valid_q <= s1_vld;
      derr_q  <= 1'b0;
      if (bus.errclr) begin
        perra_q <= 1'b0;
        perrb_q <= 1'b0;
        disag_q <= 1'b0;
        chst_q  <= BOTH_OK;
      end
      if (s1_vld) begin
        data_q <= sel_data;
        derr_q <= sel_derr;
        chst_q <= next_st;
        if (!a_good) perra_q <= 1'b1;
        if (!b_good) perrb_q <= 1'b1;
        if (a_good && b_good && (s1_a[13:1] != s1_b[13:1])) disag_q <= 1'b1;
      end
    end
  end

`ifdef PARITY_ERRCNT_EN
  logic [CNT_W-1:0] errcnt_q;

  // Counts samples with a parity error on either channel, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      errcnt_q <= '0;
    end else if (s1_vld && (!a_good || !b_good) && (errcnt_q != {CNT_W{1'b1}})) begin
      errcnt_q <= errcnt_q + 1'b1;
    end
  end

  assign bus.errcnt = errcnt_q;
`else
  assign bus.errcnt = {CNT_W{1'b0}};
`endif

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.perra = perra_q;
  assign bus.perrb = perrb_q;
  assign bus.disag = disag_q;
  assign bus.derr  = derr_q;
  assign bus.chst  = chst_q;

endmodule

// File: tb/tb_memory_parity_check.sv
// Directed, table-driven bench for memory_parity_check (odd parity, 4-bit counter),
// with hand-written sequences for saturation and reset-in-flight.
module tb_memory_parity_check;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  memory_parity_check_if #(.CNT_W(CNT_W)) bus ();

  memory_parity_check #(.PAR_ODD(1), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [14:1] bra;
    logic [14:1] brb;
    logic        clr;
    logic [13:1] data;
    logic        perra;
    logic        perrb;
    logic        disag;
    logic        derr;
    logic [1:0]  chst;
    int          cnt;
  } vec_t;

  vec_t vecs[13];
  int   nChecks = 0;
  int   nFails  = 0;

  // Counter value the build should show, given the number of errored samples so far.
  function automatic int expCnt(input int c);
`ifdef PARITY_ERRCNT_EN
    int maxv;
    maxv = (1 << CNT_W) - 1;
    return (c > maxv) ? maxv : c;
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered #1 after an edge; strobe one sample, optionally clear on its check edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    bus.bra  = v.bra;
    bus.brb  = v.brb;
    bus.syls = 1'b1;
    @(posedge clk); #1;
    bus.syls   = 1'b0;
    bus.errclr = v.clr;
    checkOutput($sformatf("v%0d.early_valid", idx), bus.valid, 0);
    @(posedge clk); #1;
    bus.errclr = 1'b0;
    checkOutput($sformatf("v%0d.valid", idx), bus.valid, 1);
    checkOutput($sformatf("v%0d.data", idx),  bus.data,  v.data);
    checkOutput($sformatf("v%0d.perra", idx), bus.perra, v.perra);
    checkOutput($sformatf("v%0d.perrb", idx), bus.perrb, v.perrb);
    checkOutput($sformatf("v%0d.disag", idx), bus.disag, v.disag);
    checkOutput($sformatf("v%0d.derr", idx),  bus.derr,  v.derr);
    checkOutput($sformatf("v%0d.chst", idx),  bus.chst,  v.chst);
    checkOutput($sformatf("v%0d.errcnt", idx), bus.errcnt, expCnt(v.cnt));
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d.valid_drop", idx), bus.valid, 0);
    checkOutput($sformatf("v%0d.data_hold", idx),  bus.data,  v.data);
  endtask

  initial begin
    int vcount;

    //               bra       brb       clr  data      pa pb dg de chst cnt
    vecs[0]  = '{14'h0001, 14'h0001, 1'b0, 13'h0001, 0, 0, 0, 0, 2'd0, 0};
    vecs[1]  = '{14'h0000, 14'h0001, 1'b0, 13'h0001, 1, 0, 0, 0, 2'd2, 1};
    vecs[2]  = '{14'h0000, 14'h0003, 1'b0, 13'h0000, 1, 1, 0, 1, 2'd3, 2};
    vecs[3]  = '{14'h0001, 14'h0002, 1'b1, 13'h0001, 0, 0, 1, 0, 2'd0, 2};
    vecs[4]  = '{14'h0001, 14'h0001, 1'b0, 13'h0001, 0, 0, 1, 0, 2'd0, 2};
    vecs[5]  = '{14'h0000, 14'h0001, 1'b1, 13'h0001, 1, 0, 0, 0, 2'd2, 3};
    vecs[6]  = '{14'h0000, 14'h0007, 1'b0, 13'h0007, 1, 0, 0, 0, 2'd2, 4};
    vecs[7]  = '{14'h0001, 14'h0003, 1'b0, 13'h0001, 1, 1, 0, 1, 2'd3, 5};
    vecs[8]  = '{14'h0002, 14'h0002, 1'b0, 13'h0002, 1, 1, 0, 1, 2'd3, 5};
    vecs[9]  = '{14'h0002, 14'h0000, 1'b1, 13'h0002, 0, 1, 0, 0, 2'd1, 6};
    vecs[10] = '{14'h0004, 14'h0004, 1'b0, 13'h0004, 0, 1, 0, 0, 2'd1, 6};
    vecs[11] = '{14'h0008, 14'h0000, 1'b0, 13'h0008, 0, 1, 0, 0, 2'd1, 7};
    vecs[12] = '{14'h0000, 14'h0010, 1'b0, 13'h0000, 1, 1, 0, 1, 2'd3, 8};

    reset      = 1'b1;
    bus.bra    = '0;
    bus.brb    = '0;
    bus.syls   = 1'b0;
    bus.errclr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.valid",  bus.valid,  0);
    checkOutput("rst.data",   bus.data,   0);
    checkOutput("rst.perra",  bus.perra,  0);
    checkOutput("rst.perrb",  bus.perrb,  0);
    checkOutput("rst.disag",  bus.disag,  0);
    checkOutput("rst.derr",   bus.derr,   0);
    checkOutput("rst.chst",   bus.chst,   0);
    checkOutput("rst.errcnt", bus.errcnt, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);

    // Clear with no sample in flight: flags and state drop, counter keeps its value.
    bus.errclr = 1'b1;
    @(posedge clk); #1;
    bus.errclr = 1'b0;
    checkOutput("clr.chst",   bus.chst,   0);
    checkOutput("clr.perra",  bus.perra,  0);
    checkOutput("clr.perrb",  bus.perrb,  0);
    checkOutput("clr.valid",  bus.valid,  0);
    checkOutput("clr.errcnt", bus.errcnt, expCnt(8));

    // Twenty back-to-back bad samples: every one yields a pulse, counter pins at max.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("sat.reset_errcnt", bus.errcnt, 0);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      bus.bra  = 14'h0000;
      bus.brb  = 14'h0000;
      bus.syls = 1'b1;
      @(posedge clk); #1;
      if (bus.valid === 1'b1) vcount++;
    end
    bus.syls = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.valid === 1'b1) vcount++;
    end
    checkOutput("sat.valid_count", vcount, 20);
    checkOutput("sat.errcnt", bus.errcnt, expCnt(20));
    checkOutput("sat.chst",   bus.chst,   3);

    // Reset while a sample sits in stage 1: no pulse may come out.
    bus.bra  = 14'h0001;
    bus.brb  = 14'h0001;
    bus.syls = 1'b1;
    @(posedge clk); #1;
    bus.syls = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midrst.valid0", bus.valid,  0);
    checkOutput("midrst.errcnt", bus.errcnt, 0);
    checkOutput("midrst.chst",   bus.chst,   0);
    @(posedge clk); #1;
    checkOutput("midrst.valid1", bus.valid, 0);

    // Reset and strobe on the same edge: reset wins, nothing enters the pipe.
    reset      = 1'b1;
    bus.syls   = 1'b1;
    bus.errclr = 1'b1;
    @(posedge clk); #1;
    reset      = 1'b0;
    bus.syls   = 1'b0;
    bus.errclr = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstsyls.valid0", bus.valid, 0);
    @(posedge clk); #1;
    checkOutput("rstsyls.valid1", bus.valid, 0);
    checkOutput("rstsyls.data",   bus.data,  0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/memory_parity_check.md
MEMORY_PARITY_CHECK -- requirements
Module: memory_parity_check

Interface
REQ-001 SHALL have parameter PAR_ODD, default 1, meaning the parity sense: 1 = odd parity, 0 = even parity.
REQ-002 SHALL have parameter CNT_W, default 4, meaning the error counter width in bits.
REQ-003 CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 BRA  input  14  duplex channel A buffer register; bits 13:1 are data (BRA1..BRA13), bit 14 is parity (BRA14).
REQ-006 BRB  input  14  duplex channel B buffer register, same layout as BRA.
REQ-007 SYLS  input  1  sample strobe: BRA and BRB are valid this cycle.
REQ-008 ERRCLR  input  1  clears sticky flags and returns the channel state to BOTH_OK.
REQ-009 DATA  output  13  selected data word.
REQ-010 VALID  output  1  one-cycle pulse; DATA and the flags are updated for this sample.
REQ-011 PERRA, PERRB  output  1 each  sticky parity-error flags for channel A and channel B.
REQ-012 DISAG  output  1  sticky flag: A and B disagree while both have good parity.
REQ-013 DERR  output  1  current sample had no usable channel (non-sticky; valid while VALID=1).
REQ-014 CHST  output  2  channel state: 0 BOTH_OK, 1 A_ONLY, 2 B_ONLY, 3 FAILED.
REQ-015 ERRCNT  output  CNT_W  saturating count of samples with any parity error.

Function
REQ-016 SHALL capture BRA and BRB into stage-1 registers on any edge where SYLS=1; stage 1 SHALL accept a strobe every cycle, fully pipelined.
REQ-017 SHALL compute parity per channel in stage 2: the channel is good when the popcount of its 14 bits is odd (PAR_ODD=1) or even (PAR_ODD=0).
REQ-018 SHALL assert VALID for exactly one cycle, 2 clocks after the SYLS edge, i.e. SYLS sampled at edge n gives VALID=1 in the cycle following edge n+1.
REQ-019 Selection: use A if A is good and CHST is BOTH_OK or A_ONLY; otherwise use B if B is good and CHST is BOTH_OK or B_ONLY; otherwise output A data with DERR=1.
REQ-020 Transitions on each checked sample:
- BOTH_OK: A bad only -> B_ONLY; B bad only -> A_ONLY; both bad -> FAILED.
- A_ONLY: A bad -> FAILED.
- B_ONLY: B bad -> FAILED.
- FAILED: holds.
REQ-021 A parity error SHALL set PERRA, and a B parity error SHALL set PERRB, in the same edge as VALID rises.
REQ-022 When both channels are good and BRA[13:1] != BRB[13:1], SHALL set DISAG and select A; CHST SHALL be unchanged.
REQ-023 ERRCLR SHALL clear PERRA, PERRB and DISAG and set CHST=BOTH_OK, but SHALL NOT clear ERRCNT; if it coincides with a checked sample, the sample's errors and transition SHALL apply after the clear (error wins).
REQ-024 ERRCNT SHALL increment by 1 per sample with any parity error and saturate at all-ones.
REQ-025 DATA SHALL hold its last value between VALID pulses.

Reset
REQ-026 RESET SHALL clear both pipeline stages, so no VALID follows a strobe captured before reset.
REQ-027 RESET SHALL set DATA=0, VALID=0, PERRA=0, PERRB=0, DISAG=0, DERR=0, CHST=0 (BOTH_OK) and ERRCNT=0.
REQ-028 RESET SHALL override SYLS and ERRCLR on the same edge.

Configuration
REQ-029 Macro PARITY_ERRCNT_EN: when defined, ERRCNT SHALL count per REQ-024; when undefined, ERRCNT SHALL be tied to 0 and no counter logic SHALL be built.

Verification
REQ-030 BRA=BRB=14'h0001, SYLS pulse -> VALID 2 clocks later, DATA=13'h0001, CHST=0, no flags set.
REQ-031 BRA=14'h0000, BRB=14'h0001 -> PERRA=1, CHST=2, DATA=13'h0001, ERRCNT=1.
REQ-032 In CHST=2, apply BRB=14'h0003 (even) -> CHST=3, DERR=1, PERRB=1, DATA=BRA[13:1].
REQ-033 BRA=14'h0001, BRB=14'h0002 (both good, data differ) -> DISAG=1, DATA=13'h0001, CHST unchanged.
REQ-034 ERRCLR on the same edge as a checked sample with A bad -> PERRB=0, PERRA=1, CHST=2.
REQ-035 20 back-to-back bad samples with CNT_W=4 -> ERRCNT saturates at 15; RESET mid-pipeline -> no VALID emitted.
